// File: rtl/grn_pkg.sv
// Shared definitions for the GRN write-side blocks.
//   t_wr_state     : line writer state machine states
//   LINE_WIDTH     : width of one result / cache line
//   PAIRS_PER_LINE : {transient length, configuration} pairs per line
//   STATUS_FLAG    : completion marker placed in the status line
//   status_line()  : builds the completion line from the issued line count
package grn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    STATUS,
    WAIT_RSP,
    DONE
  } t_wr_state;

  localparam int LINE_WIDTH     = 512;
  localparam int PAIRS_PER_LINE = 8;
  localparam int PAIR_WIDTH     = LINE_WIDTH / PAIRS_PER_LINE;

  localparam logic [31:0] STATUS_FLAG = 32'h0000_0001;

  // Status line: first pair carries {flag, line count}; everything else zero.
  function automatic logic [LINE_WIDTH-1:0] status_line(input logic [31:0] count);
    logic [LINE_WIDTH-1:0] line;
    line = '0;
    line[PAIR_WIDTH-1:0] = {STATUS_FLAG, count};
    return line;
  endfunction

endpackage

// File: rtl/grn_line_fifo.sv
// Synchronous FIFO with show-ahead output.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write data_i (accepted when not full, or when full and popping)
//   pop_i     : discard the head entry (ignored when empty)
//   data_i    : write data
//   data_o    : current head entry, valid while empty_o is low
//   full_o    : DEPTH entries held
//   empty_o   : no entries held
module grn_line_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/grn_line_writer.sv
// Write-side consumer of the GRN result stream.
// Captures 512-bit result lines over req_write/ack_write into a FIFO, writes
// them to consecutive cache-line addresses from base_addr, and after finish
// drains, writes one status line to status_addr, waits for every write
// response and raises done.
//   clk, rst         : clock, synchronous active-high reset
//   start            : pulse in IDLE; latches base_addr/status_addr
//   req_write        : source holds a line on transient until ack_write
//   ack_write        : one-cycle capture acknowledge
//   finish           : level, source has produced its last line
//   wr_valid/addr/data : one-cycle write request per line
//   wr_almost_full   : no new write request while high
//   wr_rsp_valid     : one write completion per pulse
//   lines_written    : result lines issued (status line excluded)
//   done             : sticky completion flag
module grn_line_writer
  import grn_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 42,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] status_addr,
  input  logic                  req_write,
  input  logic [LINE_WIDTH-1:0] transient,
  output logic                  ack_write,
  input  logic                  finish,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [LINE_WIDTH-1:0] wr_data,
  input  logic                  wr_almost_full,
  input  logic                  wr_rsp_valid,
  output logic [CNT_WIDTH-1:0]  lines_written,
  output logic                  done
);

  t_wr_state             state_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] status_q;
  logic                  ack_q;
  logic                  wr_valid_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LINE_WIDTH-1:0] wr_data_q;
  logic [CNT_WIDTH-1:0]  lines_q;
  logic [CNT_WIDTH-1:0]  outstanding_q;
  logic [CNT_WIDTH-1:0]  outstanding_d;
  logic                  done_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [LINE_WIDTH-1:0] fifo_head;

  logic                  accepting;
  logic                  pop;
  logic                  push;
  logic                  status_fire;
  logic                  issue;
  logic                  rsp_take;
  logic [31:0]           lines_32;

  always_comb begin
    accepting   = (state_q == RUN) || (state_q == DRAIN);
    pop         = accepting && !fifo_empty && !wr_almost_full;
    // ack_q guard: the source still drives req_write during the ack cycle.
    push        = accepting && req_write && !ack_q && (!fifo_full || pop);
    status_fire = (state_q == STATUS) && !wr_almost_full;
    issue       = pop || status_fire;
    // A response with nothing outstanding is stray and is dropped.
    rsp_take    = wr_rsp_valid && (outstanding_q != '0);
    // Counted at the issuing edge so WAIT_RSP never sees a stale zero.
    outstanding_d = outstanding_q + CNT_WIDTH'(issue) - CNT_WIDTH'(rsp_take);
    lines_32    = 32'(lines_q);
  end

  grn_line_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LINE_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (transient),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      status_q      <= '0;
      ack_q         <= 1'b0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      lines_q       <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else begin
      ack_q         <= push;
      wr_valid_q    <= issue;
      outstanding_q <= outstanding_d;

      if (pop) begin
        // Address wraps modulo 2^ADDR_WIDTH.
        wr_addr_q <= base_q + ADDR_WIDTH'(lines_q);
        wr_data_q <= fifo_head;
        lines_q   <= lines_q + CNT_WIDTH'(1);
      end else if (status_fire) begin
        wr_addr_q <= status_q;
        wr_data_q <= status_line(lines_32);
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            status_q <= status_addr;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // A pending handshake keeps us here until it completes.
          if (fifo_empty && !req_write) begin
            state_q <= STATUS;
          end
        end
        STATUS: begin
          if (status_fire) begin
            state_q <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (outstanding_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_write     = ack_q;
  assign wr_valid      = wr_valid_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign lines_written = lines_q;
  assign done          = done_q;

endmodule

// File: tb/tb_grn_line_writer.sv
// Self-checking bench for grn_line_writer: a table of scenarios plus random
// runs, each compared against an expected write list built from the line
// order, base address arithmetic and the status line format.
module tb_grn_line_writer;

  localparam int AW = 42;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] status_addr;
  logic          req_write;
  logic [LW-1:0] transient;
  logic          ack_write;
  logic          finish;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic          wr_almost_full;
  logic          wr_rsp_valid;
  logic [31:0]   lines_written;
  logic          done;

  grn_line_writer #(
    .FIFO_DEPTH (8),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .status_addr    (status_addr),
    .req_write      (req_write),
    .transient      (transient),
    .ack_write      (ack_write),
    .finish         (finish),
    .wr_valid       (wr_valid),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_almost_full (wr_almost_full),
    .wr_rsp_valid   (wr_rsp_valid),
    .lines_written  (lines_written),
    .done           (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [AW-1:0] base;
    logic [AW-1:0] saddr;
    int          af_mode;      // 0 none, 1 hold for af_hold cycles, 2 random
    int          af_hold;
    int          exp_af_acks;
    int          rsp_delay;    // 0 = random 1..8
    logic [31:0] exp_lw;
    logic [AW-1:0] exp_last_addr;
    bit          pattern;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_addr[$];
  logic [LW-1:0] exp_data[$];
  logic [AW-1:0] got_addr[$];
  logic [LW-1:0] got_data[$];
  logic [LW-1:0] src_lines[$];
  int            rsp_due[$];

  int cyc          = 0;
  int rsp_sent     = 0;
  int last_rsp_cyc = -1;
  int ack_cnt      = 0;
  int done_cyc     = 0;
  int rsp_delay_cfg = 1;
  bit done_seen    = 0;
  bit stray_req    = 0;
  bit af_prev      = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Responder: one response per cycle, in issue order, once due.
  initial begin
    wr_rsp_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      wr_rsp_valid = 1'b0;
      if (stray_req) begin
        wr_rsp_valid = 1'b1;
        stray_req = 0;
      end else if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        void'(rsp_due.pop_front());
        wr_rsp_valid = 1'b1;
        rsp_sent++;
        last_rsp_cyc = cyc;
      end
    end
  end

  // Monitor: captures writes and acks, checks the backpressure rule.
  initial begin
    forever begin
      @(negedge clk);
      if (ack_write) ack_cnt++;
      if (wr_valid) begin
        chk("issue_under_almost_full", LW'(af_prev), LW'(0));
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
        rsp_due.push_back(cyc + ((rsp_delay_cfg == 0) ? int'($urandom_range(1, 8)) : rsp_delay_cfg));
      end
      af_prev = wr_almost_full;
      if (done && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got simulation still running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs();
    chk("rst_ack_valid_done", LW'({ack_write, wr_valid, done}), LW'(0));
    chk("rst_wr_addr", LW'(wr_addr), LW'(0));
    chk("rst_wr_data", wr_data, LW'(0));
    chk("rst_lines_written", LW'(lines_written), LW'(0));
  endtask

  // GRN top model: holds each line until ack, drops it after the ack cycle.
  task automatic source(input int n, input bit gaps);
    bit got;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        req_write = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      req_write = 1'b1;
      transient = src_lines[i];
      got = 0;
      for (int w = 0; w < 500 && !got; w++) begin
        @(negedge clk);
        if (ack_write) got = 1;
      end
      chk($sformatf("ack_arrives[%0d]", i), LW'(got), LW'(1));
      if (!got) begin
        req_write = 1'b0;
        return;
      end
      tick();
    end
    req_write = 1'b0;
  endtask

  task automatic af_drive(input int mode, input int hold, input int exp_acks);
    if (mode == 1) begin
      repeat (hold) tick();
      chk("acks_under_backpressure", LW'(ack_cnt), LW'(exp_acks));
      wr_almost_full = 1'b0;
    end else if (mode == 2) begin
      for (int k = 0; k < 3000 && !done_seen; k++) begin
        wr_almost_full = ($urandom_range(0, 3) == 0);
        tick();
      end
      wr_almost_full = 1'b0;
    end
  endtask

  task automatic clear_book();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    src_lines.delete();
    ack_cnt      = 0;
    rsp_sent     = 0;
    last_rsp_cyc = -1;
    done_seen    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_write = 1'b0;
    start = 1'b0;
    finish = 1'b0;
    wr_almost_full = 1'b0;
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic build_model(input vec_t v);
    logic [LW-1:0] line;
    logic [3:0]    nib;
    for (int i = 0; i < v.n; i++) begin
      if (v.pattern) begin
        nib  = 4'(4'hA + i);
        line = {128{nib}};
      end else begin
        for (int w = 0; w < 16; w++) line[w*32 +: 32] = $urandom();
      end
      src_lines.push_back(line);
      exp_addr.push_back(v.base + AW'(i));
      exp_data.push_back(line);
    end
    line = '0;
    line[31:0]  = 32'(v.n);
    line[63:32] = 32'h0000_0001;
    exp_addr.push_back(v.saddr);
    exp_data.push_back(line);
  endtask

  task automatic run_case(input int id, input vec_t v, input bit with_reset, input bit gaps);
    int ncmp;
    if (with_reset) do_reset();
    clear_book();
    rsp_delay_cfg = v.rsp_delay;
    build_model(v);
    stray_req = 1;          // arrives with nothing outstanding
    tick();
    tick();
    wr_almost_full = (v.af_mode == 1);
    base_addr   = v.base;
    status_addr = v.saddr;
    start = 1'b1;
    tick();
    start = 1'b0;
    fork
      begin
        source(v.n, gaps);
        finish = 1'b1;
      end
      af_drive(v.af_mode, v.af_hold, v.exp_af_acks);
    join
    for (int k = 0; k < 3000 && !done_seen; k++) tick();
    chk("done_reached", LW'(done_seen), LW'(1));
    chk("write_count", LW'(got_addr.size()), LW'(v.n + 1));
    ncmp = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < ncmp; i++) begin
      chk($sformatf("wr_addr[%0d]", i), LW'(got_addr[i]), LW'(exp_addr[i]));
      chk($sformatf("wr_data[%0d]", i), got_data[i], exp_data[i]);
    end
    if (v.n > 0 && got_addr.size() >= v.n)
      chk("last_data_addr", LW'(got_addr[v.n-1]), LW'(v.exp_last_addr));
    chk("lines_written", LW'(lines_written), LW'(v.exp_lw));
    chk("ack_count", LW'(ack_cnt), LW'(v.n));
    chk("rsp_before_done", LW'(rsp_sent), LW'(v.n + 1));
    chk("done_latency", LW'(done_cyc - last_rsp_cyc), LW'(2));
    repeat (3) tick();
    chk("done_sticky", LW'(done), LW'(1));
    $display("case %0d: lines=%0d base=%0h writes=%0d lines_written=%0d done=%0b",
             id, v.n, v.base, got_addr.size(), lines_written, done);
    finish = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    vec_t v;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    status_addr = '0;
    req_write = 1'b0;
    transient = '0;
    finish = 1'b0;
    wr_almost_full = 1'b0;

    vecs[0] = '{n:3,  base:42'h1000, saddr:42'h2000, af_mode:0, af_hold:0,  exp_af_acks:0,
                rsp_delay:2,  exp_lw:32'd3,  exp_last_addr:42'h1002, pattern:1'b1};
    vecs[1] = '{n:10, base:42'h4000, saddr:42'h8000, af_mode:1, af_hold:20, exp_af_acks:8,
                rsp_delay:1,  exp_lw:32'd10, exp_last_addr:42'h4009, pattern:1'b0};
    vecs[2] = '{n:4,  base:42'h10,   saddr:42'h3F,   af_mode:1, af_hold:12, exp_af_acks:4,
                rsp_delay:30, exp_lw:32'd4,  exp_last_addr:42'h13,   pattern:1'b0};
    vecs[3] = '{n:4,  base:42'h3FF_FFFF_FFFE, saddr:42'h0, af_mode:0, af_hold:0, exp_af_acks:0,
                rsp_delay:3,  exp_lw:32'd4,  exp_last_addr:42'h1,    pattern:1'b0};
    vecs[4] = '{n:0,  base:42'h500,  saddr:42'h600,  af_mode:0, af_hold:0,  exp_af_acks:0,
                rsp_delay:5,  exp_lw:32'd0,  exp_last_addr:42'h0,    pattern:1'b0};

    for (int t = 0; t < 5; t++) run_case(t, vecs[t], 1'b1, 1'b0);

    // Random runs: random lengths, bases (some near the wrap), backpressure,
    // response delays and source gaps.
    for (int r = 0; r < 6; r++) begin
      v.n = $urandom_range(1, 20);
      if (r % 2 == 0) v.base = '1 - AW'($urandom_range(0, 6));
      else            v.base = AW'({$urandom(), $urandom()});
      v.saddr = AW'({$urandom(), $urandom()});
      v.af_mode = 2;
      v.af_hold = 0;
      v.exp_af_acks = 0;
      v.rsp_delay = 0;
      v.exp_lw = 32'(v.n);
      v.exp_last_addr = v.base + AW'(v.n - 1);
      v.pattern = 1'b0;
      run_case(10 + r, v, 1'b1, 1'b1);
    end

    // Reset mid-run: 5 lines captured, 2 issued, then reset and a fresh run.
    do_reset();
    clear_book();
    rsp_delay_cfg = 1;
    v = vecs[0];
    v.n = 5;
    v.pattern = 1'b0;
    build_model(v);
    wr_almost_full = 1'b1;
    base_addr = 42'h7000;
    status_addr = 42'h7F00;
    start = 1'b1;
    tick();
    start = 1'b0;
    source(5, 1'b0);
    chk("midrun_acks", LW'(ack_cnt), LW'(5));
    wr_almost_full = 1'b0;
    tick();
    tick();
    wr_almost_full = 1'b1;
    repeat (4) tick();
    chk("midrun_lines_before_rst", LW'(lines_written), LW'(2));
    chk("midrun_first_addr", LW'(got_addr.size() > 0 ? got_addr[0] : '1), LW'(42'h7000));
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0;
    wr_almost_full = 1'b0;
    v = '{n:2, base:42'h9000, saddr:42'h9100, af_mode:0, af_hold:0, exp_af_acks:0,
          rsp_delay:1, exp_lw:32'd2, exp_last_addr:42'h9001, pattern:1'b0};
    run_case(20, v, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
